// File: rtl/user_input_irq_ctrl_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and user_input_irq_ctrl.
// Read data follows a read strobe by exactly one clock; there is no waitrequest.
interface user_input_irq_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/user_input_irq_ctrl.sv
// Debounced key/switch edge interrupt controller with W1C pending bits and a level irq.
// Optional event counter at address 4 is built only when USER_INPUT_IRQ_COUNT_EN is defined.
module user_input_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [1:0]                  user_input_keys,
  input  logic [3:0]                  user_input_switches,
  user_input_irq_ctrl_if.slave        avs,
  output logic                        irq
);

  localparam int unsigned NB       = 6;
  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  KEY_INV  = KEY_ACTIVE_LOW ? 6'b000011 : 6'b000000;

  localparam logic [2:0] ADDR_STATE   = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser for {switches, keys}
  // ---------------------------------------------------------------------
  logic [NB-1:0] meta_q, meta_d;
  logic [NB-1:0] sync_q, sync_d;
  logic [NB-1:0] sync_eff;

  always_comb begin
    meta_d = {user_input_switches, user_input_keys};
    sync_d = meta_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // Keys are flipped after synchronisation so pressed reads as 1.
  assign sync_eff = sync_q ^ KEY_INV;

  // ---------------------------------------------------------------------
  // Per-bit debounce
  // ---------------------------------------------------------------------
  wire [NB-1:0] debounced;

  for (genvar gi = 0; gi < NB; gi++) begin : g_deb
    logic [19:0] cnt_q, cnt_d;
    logic        deb_q, deb_d;

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync_eff[gi] == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q >= DEB_LAST) begin
        deb_d = sync_eff[gi];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign debounced[gi] = deb_q;
  end

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic [NB-1:0] prev_q, prev_d;
  logic [NB-1:0] rise_en_q, rise_en_d;
  logic [NB-1:0] fall_en_q, fall_en_d;
  logic [NB-1:0] rise_w, fall_w, event_w;

  assign rise_w  = debounced & ~prev_q;
  assign fall_w  = ~debounced & prev_q;
  assign event_w = (rise_w & rise_en_q) | (fall_w & fall_en_q);

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [NB-1:0] pending_q, pending_d;
  logic [NB-1:0] mask_q, mask_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [NB-1:0] w1c_clr;
  logic          wr_pending, wr_mask, wr_edge;

  assign wr_pending = avs.avs_write && (avs.avs_address == ADDR_PENDING);
  assign wr_mask    = avs.avs_write && (avs.avs_address == ADDR_MASK);
  assign wr_edge    = avs.avs_write && (avs.avs_address == ADDR_EDGE);
  assign w1c_clr    = wr_pending ? avs.avs_writedata[5:0] : '0;

`ifdef USER_INPUT_IRQ_COUNT_EN
  logic [15:0] count_q, count_d;
  logic [2:0]  event_pop;
  logic [16:0] count_sum;
  logic        wr_count;

  assign wr_count = avs.avs_write && (avs.avs_address == ADDR_COUNT);

  always_comb begin
    event_pop = '0;
    for (int i = 0; i < NB; i++) begin
      event_pop = event_pop + {2'b00, event_w[i]};
    end
    count_sum = {1'b0, count_q} + {14'd0, event_pop};
    // A clearing write still counts events landing on the same edge.
    if (wr_count) begin
      count_d = {13'd0, event_pop};
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = count_sum[15:0];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

  always_comb begin
    prev_d    = debounced;
    rise_en_d = wr_edge ? avs.avs_writedata[5:0]  : rise_en_q;
    fall_en_d = wr_edge ? avs.avs_writedata[13:8] : fall_en_q;
    mask_d    = wr_mask ? avs.avs_writedata[5:0]  : mask_q;
    // Setting after clearing lets a same-cycle event win over W1C.
    pending_d = (pending_q & ~w1c_clr) | event_w;
    irq_d     = |(pending_q & mask_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        ADDR_STATE:   rdata_d = {26'd0, debounced};
        ADDR_PENDING: rdata_d = {26'd0, pending_q};
        ADDR_MASK:    rdata_d = {26'd0, mask_q};
        ADDR_EDGE:    rdata_d = {18'd0, fall_en_q, 2'b00, rise_en_q};
`ifdef USER_INPUT_IRQ_COUNT_EN
        ADDR_COUNT:   rdata_d = {16'd0, count_q};
`endif
        default:      rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev_q    <= '0;
      rise_en_q <= 6'h3F;
      fall_en_q <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq              = irq_q;
  assign avs.avs_readdata = rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^{avs.avs_writedata[31:14], avs.avs_writedata[7:6]};

endmodule

// File: tb/tb_user_input_irq_ctrl.sv
// Self-checking bench for user_input_irq_ctrl with a window-based behavioural model.
// Counter checks are included when USER_INPUT_IRQ_COUNT_EN is defined.
module tb_user_input_irq_ctrl;

  localparam int DEB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] keys  = 2'b11;
  logic [3:0] sw    = 4'b0000;
  logic       irq;

  int total = 0;
  int bad   = 0;

  user_input_irq_ctrl_if bus();

  user_input_irq_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .user_input_keys     (keys),
    .user_input_switches (sw),
    .avs                 (bus.slave),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Debounced bit flips once the last DEB synchronised samples all disagree with it.
  logic [5:0]  r1_m = '0, r2_m = '0;
  logic [5:0]  hist [DEB];
  logic [5:0]  deb_m = '0, prev_m = '0, pend_m = '0, mask_m = '0;
  logic [5:0]  rise_m = 6'h3F, fall_m = '0;
  logic        irq_m = 1'b0;
  logic [31:0] rd_m = '0;
  logic [15:0] cnt_m = '0;
  logic [5:0]  s_eff, nd, ev, clr;
  int          pop, csum;
  bit          all_diff;

  initial for (int k = 0; k < DEB; k++) hist[k] = '0;

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return {26'd0, deb_m};
      3'd1: return {26'd0, pend_m};
      3'd2: return {26'd0, mask_m};
      3'd3: return {18'd0, fall_m, 2'b00, rise_m};
`ifdef USER_INPUT_IRQ_COUNT_EN
      3'd4: return {16'd0, cnt_m};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      r1_m = '0; r2_m = '0;
      for (int k = 0; k < DEB; k++) hist[k] = '0;
      deb_m = '0; prev_m = '0; pend_m = '0; mask_m = '0;
      rise_m = 6'h3F; fall_m = '0; irq_m = 1'b0; rd_m = '0; cnt_m = '0;
    end else begin
      s_eff = r2_m ^ 6'b000011;
      r2_m  = r1_m;
      r1_m  = {sw, keys};
      for (int k = DEB - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s_eff;
      nd = deb_m;
      for (int i = 0; i < 6; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[k][i] == deb_m[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~deb_m[i];
      end
      ev  = (deb_m & ~prev_m & rise_m) | (~deb_m & prev_m & fall_m);
      pop = $countones(ev);
      if (bus.avs_read) rd_m = reg_val(bus.avs_address);
      irq_m = |(pend_m & mask_m);
      clr   = '0;
      csum  = int'(cnt_m) + pop;
      cnt_m = (csum > 65535) ? 16'hFFFF : 16'(csum);
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd1: clr = bus.avs_writedata[5:0];
          3'd2: mask_m = bus.avs_writedata[5:0];
          3'd3: begin rise_m = bus.avs_writedata[5:0]; fall_m = bus.avs_writedata[13:8]; end
`ifdef USER_INPUT_IRQ_COUNT_EN
          3'd4: cnt_m = 16'(pop);
`endif
          default: ;
        endcase
      end
      pend_m = (pend_m & ~clr) | ev;
      prev_m = deb_m;
      deb_m  = nd;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("irq_model", {31'd0, irq}, {31'd0, irq_m});
    chk("readdata_model", bus.avs_readdata, rd_m);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    chk(nm, bus.avs_readdata, exp);
    $display("read  addr=%0d data=%h expect=%h (%s)", a, bus.avs_readdata, exp, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    chk(nm, bus.avs_readdata, exp);
    $display("rdwr  addr=%0d wdata=%h rdata=%h expect=%h (%s)", a, d, bus.avs_readdata, exp, nm);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    rd(3'd0, 32'h0,  "reset_state");
    rd(3'd1, 32'h0,  "reset_pending");
    rd(3'd2, 32'h0,  "reset_mask");
    rd(3'd3, 32'h3F, "reset_edge");
    rd(3'd7, 32'h0,  "reset_addr7");
    chk("reset_irq", {31'd0, irq}, 32'd0);

    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0, "ro_state_write");
    rd(3'd5, 32'h0, "addr5_write");
    rd(3'd2, 32'h0, "mask_untouched");

    // 3-cycle glitch on switch[0] must be filtered out
    sw[0] = 1'b1; cyc(3); sw[0] = 1'b0;
    cyc(10);
    rd(3'd0, 32'h0, "glitch_state");
    rd(3'd1, 32'h0, "glitch_pending");

    // clean rise: debounced value visible after the 6th edge
    sw[0] = 1'b1; cyc(5);
    rd(3'd0, 32'h0, "state_before_edge6");
    rd(3'd0, 32'h4, "state_after_edge6");
    cyc(3); sw[0] = 1'b0;
    rd(3'd1, 32'h4, "pending_sw0");
    cyc(10);

    wr(3'd2, 32'h4);
    chk("irq_same_cycle_mask", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("irq_after_mask", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'h4);
    chk("irq_same_cycle_w1c", {31'd0, irq}, 32'd1);
    cyc(1);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(3'd1, 32'h0, "pending_cleared");

    // falling-edge-only on key[1]
    wr(3'd3, 32'h200);
    rd(3'd3, 32'h200, "edge_readback");
    keys[1] = 1'b0; cyc(10);
    rd(3'd1, 32'h0, "key_press_no_pend");
    keys[1] = 1'b1; cyc(10);
    rd(3'd1, 32'h2, "key_release_pend");
    wr(3'd1, 32'h2);
    rd(3'd1, 32'h0, "key_pend_cleared");

    // rise on switch[1] lands on the same edge as a W1C of bit 3
    wr(3'd3, 32'h208);
    sw[1] = 1'b1; cyc(6);
    wr(3'd1, 32'h8);
    rd(3'd1, 32'h8, "set_wins_over_clear");
    wr(3'd1, 32'h8);
    rd(3'd1, 32'h0, "bit3_cleared");

    rdwr(3'd2, 32'h3F, 32'h4, "rdwr_pre_write_value");
    rd(3'd2, 32'h3F, "rdwr_write_done");

`ifdef USER_INPUT_IRQ_COUNT_EN
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0, "count_start");
    wr(3'd3, 32'h3F3F);
    sw[0] = 1'b1; cyc(10);
    sw[2] = 1'b1; cyc(10);
    sw[3] = 1'b1; cyc(10);
    rd(3'd4, 32'h3, "count_three");
    sw[2] = 1'b0; sw[3] = 1'b0; cyc(10);
    rd(3'd4, 32'h5, "count_five");
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0, "count_cleared");
    for (int n = 0; n < 11700; n++) begin
      sw   = ~sw;
      keys = ~keys;
      cyc(5);
    end
    cyc(10);
    rd(3'd4, 32'hFFFF, "count_saturated");
`else
    wr(3'd4, 32'hFFFF);
    rd(3'd4, 32'h0, "count_absent");
`endif

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
